idu_stage_buf: RTL and testbench

Parametrised valid/ready pipeline stage buffer that replaces the single-entry idle/wait handshake controller between front-end pipeline stages (IFU→IDU, IDU→EXU). It stores up to DEPTH payload words of WIDTH bits in a circular buffer. It sustains one transfer per cycle with no combinational ready path from downstream to upstream, and supports a synchronous flush for branch redirects. An optional compile-time bypass gives zero-cycle latency when the buffer is empty.

---
 rtl/idu_stage_buf.sv | 58 +++++
 tb/tb_idu_stage_buf.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/idu_stage_buf.sv
// idu_stage_buf: valid/ready circular stage buffer with synchronous flush.
// Define STAGE_BUF_BYPASS_EN for zero-latency pass-through when empty.
module idu_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_pre_i,
  input  logic [WIDTH-1:0] data_pre_i,
  output logic             ready_pre_o,
  output logic             valid_post_o,
  output logic [WIDTH-1:0] data_post_o,
  input  logic             ready_post_i,
  output logic             we_o,
  output logic             re_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic empty, full, byp, push, pop;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
`ifdef STAGE_BUF_BYPASS_EN
  assign byp = empty & ~flush_i;
`else
  assign byp = 1'b0;
`endif
  assign ready_pre_o = ~full;
  assign valid_post_o = reset & (byp ? valid_pre_i : ~empty);
  assign data_post_o = ~reset ? '0 : byp ? data_pre_i : empty ? '0 : mem[rd_ptr];
  assign we_o = reset & valid_pre_i & ready_pre_o & ~flush_i;
  assign re_o = valid_post_o & ready_post_i & ~flush_i;
  // a bypassed transfer completes both handshakes but never touches storage
  assign push = we_o & ~(byp & re_o);
  assign pop = re_o & ~byp;
  assign count_o = count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= data_pre_i;
endmodule

// File: tb/tb_idu_stage_buf.sv
// tb_idu_stage_buf: queue-scoreboard bench for idu_stage_buf (DEPTH=2, WIDTH=32).
module tb_idu_stage_buf;
  localparam int DEPTH = 2;
  logic clock = 0, reset = 0, flush_i = 0, valid_pre_i = 0, ready_post_i = 0;
  logic [31:0] data_pre_i = 0, data_post_o;
  logic ready_pre_o, valid_post_o, we_o, re_o;
  logic [1:0] count_o;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  int n;
  logic byp, exp_v, exp_we, exp_re;
  logic [31:0] exp_d;

  idu_stage_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .valid_pre_i(valid_pre_i), .data_pre_i(data_pre_i), .ready_pre_o(ready_pre_o),
    .valid_post_o(valid_post_o), .data_post_o(data_post_o), .ready_post_i(ready_post_i),
    .we_o(we_o), .re_o(re_o), .count_o(count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock)
    if (reset) begin
      n = q.size();
`ifdef STAGE_BUF_BYPASS_EN
      byp = n == 0 && !flush_i;
`else
      byp = 1'b0;
`endif
      exp_v = byp ? valid_pre_i : n != 0;
      exp_we = valid_pre_i && n != DEPTH && !flush_i;
      exp_re = exp_v && ready_post_i && !flush_i;
      exp_d = byp ? data_pre_i : n != 0 ? q[0] : 32'h0;
      chk("mon_count", 32'(count_o), 32'(n));
      chk("mon_ready", 32'(ready_pre_o), 32'(n != DEPTH));
      chk("mon_valid", 32'(valid_post_o), 32'(exp_v));
      chk("mon_we", 32'(we_o), 32'(exp_we));
      chk("mon_re", 32'(re_o), 32'(exp_re));
      chk("mon_data", data_post_o, exp_d);
      if (flush_i) q.delete();
      else begin
        if (exp_we) q.push_back(data_pre_i);
        if (exp_re) void'(q.pop_front());
      end
    end else q.delete();

  initial begin
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(valid_post_o), 0);
    chk("rst_ready", 32'(ready_pre_o), 1);
    #11 reset = 1;
    step();
    valid_pre_i = 1; data_pre_i = 32'hA0;
    step();
    chk("fill_cnt1", 32'(count_o), 1);
    data_pre_i = 32'hA1;
    step();
    chk("fill_cnt2", 32'(count_o), 2);
    chk("fill_ready", 32'(ready_pre_o), 0);
    data_pre_i = 32'hA2;
    #1 chk("fill_we3", 32'(we_o), 0);
    valid_pre_i = 0; ready_post_i = 1;
    #1 chk("drain_d0", data_post_o, 32'hA0);
    chk("drain_re0", 32'(re_o), 1);
    step();
    chk("drain_d1", data_post_o, 32'hA1);
    chk("drain_re1", 32'(re_o), 1);
    step();
    chk("drain_empty", 32'(valid_post_o), 0);
    for (int i = 0; i < 10; i++) begin
      valid_pre_i = 1; data_pre_i = 32'(i);
      step();
      chk("stream_cnt", 32'(count_o <= 2'd1), 1);
    end
    valid_pre_i = 0;
    step();
    step();
    ready_post_i = 0; valid_pre_i = 1; data_pre_i = 32'hB0;
    step();
    data_pre_i = 32'hB1;
    step();
    chk("flush_pre_cnt", 32'(count_o), 2);
    data_pre_i = 32'hB2; ready_post_i = 1; flush_i = 1;
    #1 chk("flush_we", 32'(we_o), 0);
    chk("flush_re", 32'(re_o), 0);
    step();
    flush_i = 0; valid_pre_i = 0;
    #1 chk("flush_cnt", 32'(count_o), 0);
    chk("flush_valid", 32'(valid_post_o), 0);
`ifdef STAGE_BUF_BYPASS_EN
    valid_pre_i = 1; data_pre_i = 32'h55; ready_post_i = 1;
    #1 chk("byp_valid", 32'(valid_post_o), 1);
    chk("byp_data", data_post_o, 32'h55);
    step();
    chk("byp_cnt", 32'(count_o), 0);
    valid_pre_i = 0;
`endif
    step();
    ready_post_i = 0; valid_pre_i = 1; data_pre_i = 32'hC0;
    step();
    data_pre_i = 32'hC1;
    step();
    chk("mid_pre_cnt", 32'(count_o), 2);
    data_pre_i = 32'hC2;
    reset = 0;
    #1 chk("mid_rst_cnt", 32'(count_o), 0);
    chk("mid_rst_valid", 32'(valid_post_o), 0);
    chk("mid_rst_ready", 32'(ready_pre_o), 1);
    chk("mid_rst_data", data_post_o, 0);
    chk("mid_rst_we", 32'(we_o), 0);
    @(negedge clock);
    #1 reset = 1; valid_pre_i = 0;
    for (int i = 0; i < 300; i++) begin
      valid_pre_i = 1'($urandom_range(0, 1));
      data_pre_i = $urandom;
      ready_post_i = 1'($urandom_range(0, 1));
      flush_i = $urandom_range(0, 15) == 0;
      step();
    end
    flush_i = 0; valid_pre_i = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
